rr_write_arbiter: RTL and testbench

Parametrised round-robin arbiter that merges the write streams of `NUM_WRITERS` independent Writer modules into one FIFO write port. Each Writer presents a word and a request. The arbiter picks one requester per grant using rotating priority, registers that Writer's word onto the FIFO bus with a one-cycle write strobe, and acknowledges the Writer by dropping its busy line for exactly that cycle. It sits between the Writer array and the shared FIFO. It adds FIFO back-pressure and fairness, neither of which the previous single-writer arbiter had.

---
 rtl/rr_write_arbiter.sv | 94 +++++++++
 tb/tb_rr_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter merging NUM_WRITERS writer streams onto one FIFO port.
// One grant per two cycles; registered strobe, data, id and busy acknowledge.
module rr_write_arbiter #(
   parameter int NUM_WRITERS = 4,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [NUM_WRITERS*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_WRITERS-1:0]            i_req,
   input  logic                              i_fifo_full,
   output logic [NUM_WRITERS-1:0]            o_busy,
   output logic                              o_we,
   output logic [DATA_WIDTH-1:0]             o_data,
   output logic [$clog2(NUM_WRITERS)-1:0]    o_grant_id
);

   localparam int GW = $clog2(NUM_WRITERS);

   typedef enum logic {
      S_IDLE,
      S_ACK
   } state_t;

   state_t                  state, state_nx;
   logic [GW-1:0]           ptr, ptr_nx;
   logic [GW-1:0]           sel;
   logic [GW:0]             cand;
   logic                    found;
   logic [NUM_WRITERS-1:0]  busy_nx;
   logic                    we_nx;
   logic [DATA_WIDTH-1:0]   data_nx;
   logic [GW-1:0]           gid_nx;

   // first requester at or after ptr, wrapping around
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_WRITERS; i++) begin
         cand = {1'b0, ptr} + (GW+1)'(i);
         if (cand >= (GW+1)'(NUM_WRITERS))
            cand = cand - (GW+1)'(NUM_WRITERS);
         if (!found && i_req[cand[GW-1:0]]) begin
            found = 1'b1;
            sel   = cand[GW-1:0];
         end
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      busy_nx  = '1;
      we_nx    = 1'b0;
      data_nx  = o_data;
      gid_nx   = o_grant_id;
      unique case (state)
         S_IDLE: begin
            if (found && !i_fifo_full) begin
               state_nx     = S_ACK;
               we_nx        = 1'b1;
               busy_nx[sel] = 1'b0;
               data_nx      = i_data[sel*DATA_WIDTH +: DATA_WIDTH];
               gid_nx       = sel;
               ptr_nx       = (sel == GW'(NUM_WRITERS-1)) ? '0 : sel + 1'b1;
            end
         end
         S_ACK: begin
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         o_busy     <= '1;
         o_we       <= 1'b0;
         o_data     <= '0;
         o_grant_id <= '0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         o_busy     <= busy_nx;
         o_we       <= we_nx;
         o_data     <= data_nx;
         o_grant_id <= gid_nx;
      end
   end

endmodule

// File: tb/tb_rr_write_arbiter.sv
// Self-checking bench for rr_write_arbiter against a cycle-level
// behavioural model of the round-robin grant rules.
module tb_rr_write_arbiter;

   localparam int N = 4;
   localparam int D = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*D-1:0] data;
   logic [N-1:0]   req;
   logic           full;
   logic [N-1:0]   busy;
   logic           we;
   logic [D-1:0]   odata;
   logic [1:0]     gid;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int             m_ptr;
   bit             m_ack;
   logic [N-1:0]   e_busy;
   logic           e_we;
   logic [D-1:0]   e_data;
   logic [1:0]     e_gid;

   logic [14:0]    got, want;

   rr_write_arbiter #(.NUM_WRITERS(N), .DATA_WIDTH(D)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_data     (data),
      .i_req      (req),
      .i_fifo_full(full),
      .o_busy     (busy),
      .o_we       (we),
      .o_data     (odata),
      .o_grant_id (gid)
   );

   always #5 clk = ~clk;

   function automatic int pick(logic [N-1:0] r, int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   // advance the model by one edge using the inputs now on the pins
   task automatic model_edge();
      int k;
      if (rst) begin
         m_ptr = 0; m_ack = 0;
         e_busy = '1; e_we = 0; e_data = '0; e_gid = '0;
      end else if (m_ack) begin
         m_ack = 0; e_busy = '1; e_we = 0;
      end else begin
         k = pick(req, m_ptr);
         e_busy = '1; e_we = 0;
         if (k >= 0 && !full) begin
            e_we = 1;
            e_busy[k] = 1'b0;
            e_data = data[k*D +: D];
            e_gid = 2'(k);
            m_ptr = (k + 1) % N;
            m_ack = 1;
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      got  = {busy, we, odata, gid};
      want = {e_busy, e_we, e_data, e_gid};
   endtask

   task automatic set_word(int k, logic [D-1:0] w);
      data[k*D +: D] = w;
   endtask

   task automatic test_reset();
      rst = 1;
      for (int c = 0; c < 3; c++) begin
         req  = N'($urandom);
         data = $urandom;
         full = $urandom % 2;
         cycle();
         n_vec++;
         if (got !== want || busy !== 4'b1111 || we !== 0 || odata !== 0) begin
            n_err++;
            $display("FAIL reset c%0d got=%h want=%h", c, got, want);
         end
      end
      rst = 0; full = 0; req = 4'b0110;
      cycle();
      n_vec++;
      if (got !== want || gid !== 2'd1 || we !== 1) begin
         n_err++;
         $display("FAIL reset_first_grant got=%h want=%h", got, want);
      end
      req = 4'b0000;
      cycle();
   endtask

   task automatic test_single();
      req = 4'b0100;
      set_word(2, 8'hA5);
      cycle();
      n_vec++;
      if (got !== want || busy !== 4'b1011 || odata !== 8'hA5) begin
         n_err++;
         $display("FAIL single_strobe got=%h want=%h", got, want);
      end
      req = 4'b0000;
      cycle();
      n_vec++;
      if (got !== want || busy !== 4'b1111 || we !== 0) begin
         n_err++;
         $display("FAIL single_release got=%h want=%h", got, want);
      end
   endtask

   task automatic test_round_robin();
      rst = 1; req = '0; cycle(); rst = 0;
      for (int k = 0; k < N; k++) set_word(k, 8'(8'h10 + k));
      req = 4'b1111;
      for (int c = 0; c < 16; c++) begin
         cycle();
         n_vec++;
         if (got !== want || we !== ((c % 2) == 0)) begin
            n_err++;
            $display("FAIL round_robin c%0d got=%h want=%h", c, got, want);
         end
         if (we && odata !== 8'(8'h10 + (c / 2) % N)) begin
            n_err++;
            $display("FAIL rr_order c%0d data=%h want=%h",
                     c, odata, 8'(8'h10 + (c / 2) % N));
         end
      end
      req = '0;
      cycle();
   endtask

   task automatic test_fifo_full();
      rst = 1; cycle(); rst = 0;
      req = 4'b0011; full = 1;
      set_word(0, 8'h3C); set_word(1, 8'hC3);
      for (int c = 0; c < 5; c++) begin
         cycle();
         n_vec++;
         if (got !== want || we !== 0 || busy !== 4'b1111) begin
            n_err++;
            $display("FAIL fifo_full c%0d got=%h want=%h", c, got, want);
         end
      end
      full = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL fifo_drain c%0d got=%h want=%h", c, got, want);
         end
         if (we && c == 0 && gid !== 2'd0) begin
            n_err++;
            $display("FAIL fifo_first gid=%0d want=0", gid);
         end
         if (we && c == 2 && gid !== 2'd1) begin
            n_err++;
            $display("FAIL fifo_second gid=%0d want=1", gid);
         end
         for (int k = 0; k < N; k++) if (!busy[k]) req[k] = 1'b0;
      end
   endtask

   task automatic test_wrap_skip();
      logic [N-1:0] seq [4] = '{4'b0100, 4'b0010, 4'b0100, 4'b1001};
      logic [1:0]   ids [4] = '{2'd2, 2'd1, 2'd2, 2'd3};
      rst = 1; req = '0; cycle(); rst = 0;
      for (int s = 0; s < 4; s++) begin
         req = seq[s];
         cycle();
         n_vec++;
         if (got !== want || gid !== ids[s] || we !== 1) begin
            n_err++;
            $display("FAIL wrap_skip s%0d got=%h want=%h", s, got, want);
         end
         req = '0;
         cycle();
      end
      req = 4'b1001;
      cycle();
      n_vec++;
      if (got !== want || gid !== 2'd0) begin
         n_err++;
         $display("FAIL wrap_ptr0 got=%h want=%h", got, want);
      end
      req = '0;
      cycle();
   endtask

   task automatic test_reset_ack();
      req = 4'b0100;
      cycle();
      rst = 1;
      cycle();
      n_vec++;
      if (got !== want || busy !== 4'b1111 || we !== 0) begin
         n_err++;
         $display("FAIL reset_ack got=%h want=%h", got, want);
      end
      rst = 0; req = 4'b1111;
      cycle();
      n_vec++;
      if (got !== want || gid !== 2'd0) begin
         n_err++;
         $display("FAIL reset_ack_grant got=%h want=%h", got, want);
      end
      req = '0;
      cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         full = ($urandom % 4) == 0;
         cycle();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL random c%0d got=%h want=%h", c, got, want);
         end
         for (int k = 0; k < N; k++) begin
            if (!busy[k] || !req[k]) begin
               req[k] = ($urandom % 3) != 0;
               set_word(k, 8'($urandom));
            end else if (($urandom % 16) == 0) begin
               req[k] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      rst = 1; req = '0; data = '0; full = 0;
      m_ptr = 0; m_ack = 0;
      e_busy = '1; e_we = 0; e_data = '0; e_gid = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_fifo_full();
      test_wrap_skip();
      test_reset_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
